// File: rtl/cnet_reg_xfer.sv
// cnet_reg_xfer: queues p2n register requests and runs each one as a single CNET bus transaction.
// Optional bus timeout (timer, timeout pulse, TIMEOUT_DATA return) is built when CNET_REG_TIMEOUT_EN is defined.
module cnet_reg_xfer #(
  parameter int ADDR_WIDTH     = 27,
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA = DATA_WIDTH'(32'hDEAD_BEEF)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  p2n_req,
  input  logic                  p2n_we,
  input  logic [ADDR_WIDTH-1:0] p2n_addr,
  input  logic [DATA_WIDTH-1:0] p2n_data,
  output logic                  p2n_full,
  output logic [DATA_WIDTH-1:0] n2p_data,
  output logic                  n2p_rd_rdy,
  input  logic                  cnet_reprog,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  input  logic                  bus_ack,
  output logic                  timeout,
  output logic                  fifo_ovf
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q;
  logic             ovf_q;
  logic             push;
  logic             pop;

  logic                  memWe   [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] memAddr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] memData [FIFO_DEPTH];

  logic                  busReq_q, busReq_d;
  logic                  busWe_q, busWe_d;
  logic [ADDR_WIDTH-1:0] busAddr_q, busAddr_d;
  logic [DATA_WIDTH-1:0] busWdata_q, busWdata_d;
  logic [DATA_WIDTH-1:0] n2pData_q, n2pData_d;
  logic                  rdRdy_q, rdRdy_d;

`ifdef CNET_REG_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TMR_W-1:0] timer_q, timer_d;
  logic             timerExpired;
  logic             timeout_q, timeout_d;
`else
  logic unusedTimeoutCfg;
  assign unusedTimeoutCfg = ^{TIMEOUT_DATA, TIMEOUT_CYCLES};
`endif

  // Transaction sequencer: reprog overrides everything and returns the engine to idle silently.
  always_comb begin
    push       = p2n_req && !full_q && !cnet_reprog;
    pop        = 1'b0;
    state_d    = state_q;
    busReq_d   = busReq_q;
    busWe_d    = busWe_q;
    busAddr_d  = busAddr_q;
    busWdata_d = busWdata_q;
    n2pData_d  = n2pData_q;
    rdRdy_d    = 1'b0;
`ifdef CNET_REG_TIMEOUT_EN
    timeout_d  = 1'b0;
`endif
    if (cnet_reprog) begin
      state_d  = S_IDLE;
      busReq_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (count_q != '0) begin
            pop        = 1'b1;
            busWe_d    = memWe[rdPtr_q];
            busAddr_d  = memAddr[rdPtr_q];
            busWdata_d = memData[rdPtr_q];
            busReq_d   = 1'b1;
            state_d    = S_BUS;
          end
        end
        S_BUS: begin
          if (bus_ack) begin
            busReq_d = 1'b0;
            state_d  = S_GAP;
            if (!busWe_q) begin
              n2pData_d = bus_rdata;
              rdRdy_d   = 1'b1;
            end
          end
`ifdef CNET_REG_TIMEOUT_EN
          // An ack in the expiry cycle is taken above, so real data always beats the marker.
          else if (timerExpired) begin
            busReq_d  = 1'b0;
            timeout_d = 1'b1;
            state_d   = S_GAP;
            if (!busWe_q) begin
              n2pData_d = TIMEOUT_DATA;
              rdRdy_d   = 1'b1;
            end
          end
`endif
        end
        S_GAP: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (cnet_reprog) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (push) begin
        wrPtr_d = wrPtr_q + PTR_W'(1);
      end
      if (pop) begin
        rdPtr_d = rdPtr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      memWe[wrPtr_q]   <= p2n_we;
      memAddr[wrPtr_q] <= p2n_addr;
      memData[wrPtr_q] <= p2n_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
      busReq_q   <= 1'b0;
      busWe_q    <= 1'b0;
      busAddr_q  <= '0;
      busWdata_q <= '0;
      n2pData_q  <= '0;
      rdRdy_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      full_q     <= (count_d == CNT_W'(FIFO_DEPTH));
      ovf_q      <= p2n_req && full_q;
      busReq_q   <= busReq_d;
      busWe_q    <= busWe_d;
      busAddr_q  <= busAddr_d;
      busWdata_q <= busWdata_d;
      n2pData_q  <= n2pData_d;
      rdRdy_q    <= rdRdy_d;
    end
  end

`ifdef CNET_REG_TIMEOUT_EN
  // Timer runs only while a transaction is on the bus and saturates instead of wrapping.
  always_comb begin
    timer_d = '0;
    if (state_q == S_BUS && !cnet_reprog) begin
      timer_d = (timer_q == '1) ? timer_q : timer_q + TMR_W'(1);
    end
  end

  assign timerExpired = (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign p2n_full   = full_q;
  assign fifo_ovf   = ovf_q;
  assign bus_req    = busReq_q;
  assign bus_we     = busWe_q;
  assign bus_addr   = busAddr_q;
  assign bus_wdata  = busWdata_q;
  assign n2p_data   = n2pData_q;
  assign n2p_rd_rdy = rdRdy_q;

endmodule
